register_file: RTL and testbench

//   Architectural integer register file: the receiving end of the write-back stage.

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/pending_counter.sv | 47 ++++
 rtl/register_file.sv | 120 ++++++++++++
 tb/tb_register_file.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared integer-pipeline constants and the register-address type.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : pipeline_pkg

// File: rtl/pending_counter.sv
// Per-register count of issued-but-not-written-back instructions.
// Saturates at the top value; a decrement at zero holds zero and pulses underflow_o.
module pending_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              underflow_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    // Next count: a simultaneous issue and write-back cancel out (also at zero).
    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + PEND_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - PEND_W'(1);
            end else begin
                underflow_o = 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : pending_counter

// File: rtl/register_file.sv
// Architectural integer register file with two bypassed read ports, a
// pending-write scoreboard per register and RAW/saturation stall generation.
// x0 reads as zero, is never written and never carries a pending count.
module register_file
    import pipeline_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    input  logic            wb_en,
    input  reg_addr_t       wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            err_underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [PEND_W-1:0] pend_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] underflow_vec;
    logic              err_underflow_q;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic              full_rd;
    logic              issue_accept;

    // Register storage: write-back lands on the clock edge; x0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_en && (wb_addr == REG_ADDR_W'(i))) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // Read ports: zero for x0, same-cycle write-back bypass, else storage.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            if (wb_en && (wb_addr == rs1_addr)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
        if (rs2_addr != '0) begin
            if (wb_en && (wb_addr == rs2_addr)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    // Scoreboard: one counter per writable register; x0 is a constant zero.
    assign pend_cnt[0]      = '0;
    assign underflow_vec[0] = 1'b0;
    assign issue_accept     = issue_valid && !stall;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            pending_counter #(
                .PEND_W (PEND_W)
            ) u_pend (
                .clk         (clk),
                .rst_n       (rst_n),
                .inc_i       (issue_accept && (issue_rd == REG_ADDR_W'(gi))),
                .dec_i       (wb_en && (wb_addr == REG_ADDR_W'(gi))),
                .count_o     (pend_cnt[gi]),
                .underflow_o (underflow_vec[gi])
            );
        end
    endgenerate

    // Stall: unresolved RAW on either source, or destination counter saturated.
    // A source whose only outstanding write completes this cycle is bypassed.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        full_rd    = 1'b0;
        if ((rs1_addr != '0) && (pend_cnt[rs1_addr] != '0)) begin
            hazard_rs1 = !(wb_en && (wb_addr == rs1_addr) && (pend_cnt[rs1_addr] == CNT_ONE));
        end
        if ((rs2_addr != '0) && (pend_cnt[rs2_addr] != '0)) begin
            hazard_rs2 = !(wb_en && (wb_addr == rs2_addr) && (pend_cnt[rs2_addr] == CNT_ONE));
        end
        if ((issue_rd != '0) && (pend_cnt[issue_rd] == CNT_MAX)) begin
            full_rd = !(wb_en && (wb_addr == issue_rd));
        end
        stall = hazard_rs1 || hazard_rs2 || (full_rd && issue_valid);
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow_q <= 1'b0;
        end else if (|underflow_vec) begin
            err_underflow_q <= 1'b1;
        end
    end

    assign err_underflow = err_underflow_q;

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run, all compared against an array-based model of the architectural rules.
module tb_register_file;

    localparam int NR      = 32;
    localparam int PEND_MX = 3;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [NR];
    int          m_pend [NR];
    logic        m_err;

    register_file #(.PEND_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_hazard(input logic [4:0] a);
        if (a == 0 || m_pend[a] == 0) return 1'b0;
        if (wb_en && wb_addr == a && m_pend[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        bit full;
        full = (issue_rd != 0) && (m_pend[issue_rd] == PEND_MX) && !(wb_en && wb_addr == issue_rd);
        return exp_hazard(rs1_addr) || exp_hazard(rs2_addr) || (full && issue_valid);
    endfunction

    // Apply the effect of the upcoming clock edge to the model.
    function automatic void model_commit();
        bit st;
        bit inc;
        bit dec;
        st = exp_stall();
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
        for (int r = 1; r < NR; r++) begin
            inc = issue_valid && !st && (issue_rd == r);
            dec = wb_en && (wb_addr == r);
            if (inc && !dec) begin
                if (m_pend[r] < PEND_MX) m_pend[r] = m_pend[r] + 1;
            end else if (dec && !inc) begin
                if (m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
                else m_err = 1'b1;
            end
        end
    endfunction

    task automatic set_idle();
        rs1_addr    = '0;
        rs2_addr    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < NR; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(NR - 1 - i);
            #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
            end
        end
        checks++;
        if (stall !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags stall=%b err=%b required 0 0", stall, err_underflow);
        end
        set_idle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        set_idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #2;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle got=%h required=deadbeef", rs1_data);
        end
        tick();
        wb_en = 1'b0; wb_data = 32'h0;
        #2;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_stored got=%h required=deadbeef", rs1_data);
        end
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_x0();
        set_idle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rs2_addr = 5'd0;
        #2;
        checks++;
        if (rs2_data !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_write_cycle rs2=%h stall=%b required 0 0", rs2_data, stall);
        end
        tick();
        set_idle();
        #2;
        checks++;
        if (rs2_data !== 32'h0 || err_underflow !== m_err) begin
            errors++;
            $display("FAIL x0_after rs2=%h err=%b required 0 %b", rs2_data, err_underflow, m_err);
        end
        tick();
        $display("test_x0 done");
    endtask

    task automatic test_raw_stall();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd7;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_issue stall=%b required 0", stall);
        end
        tick();
        set_idle();
        rs1_addr = 5'd7;
        #2;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_hazard stall=%b required 1", stall);
        end
        tick();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd42;
        #2;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'd42) begin
            errors++;
            $display("FAIL raw_wb_bypass stall=%b rs1=%0d required 0 42", stall, rs1_data);
        end
        tick();
        set_idle();
        rs1_addr = 5'd7;
        #2;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'd42) begin
            errors++;
            $display("FAIL raw_cleared stall=%b rs1=%0d required 0 42", stall, rs1_data);
        end
        tick();
        $display("test_raw_stall done");
    endtask

    task automatic test_saturate();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL sat_issue%0d stall=%b required 0", k, stall);
            end
            tick();
        end
        #2;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sat_full stall=%b required 1", stall);
        end
        tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h123;
        #2;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL sat_issue_with_wb stall=%b required 0", stall);
        end
        tick();
        wb_en = 1'b0;
        #2;
        checks++;
        if (stall !== 1'b1 || stall !== exp_stall()) begin
            errors++;
            $display("FAIL sat_count_held stall=%b required 1", stall);
        end
        tick();
        $display("test_saturate done");
    endtask

    task automatic test_underflow_and_reset();
        set_idle();
        do_reset();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #2;
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_before err=%b required 0", err_underflow);
        end
        tick();
        set_idle();
        rs2_addr = 5'd9;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (err_underflow !== 1'b1 || rs2_data !== 32'h99) begin
                errors++;
                $display("FAIL uf_sticky%0d err=%b rs2=%h required 1 00000099", k, err_underflow, rs2_data);
            end
            tick();
        end
        issue_valid = 1'b1; issue_rd = 5'd9; rs2_addr = 5'd0;
        tick();
        set_idle();
        rs1_addr = 5'd9;
        #2;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall stall=%b required 1", stall);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (stall !== 1'b0 || err_underflow !== 1'b0 || rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset stall=%b err=%b rs1=%h required 0 0 0", stall, err_underflow, rs1_data);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hABCD;
        repeat (2) @(posedge clk);
        #2;
        set_idle();
        rs1_addr = 5'd9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rs1_data !== 32'h0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL no_write_in_reset rs1=%h err=%b required 0 0", rs1_data, err_underflow);
        end
        $display("test_underflow_and_reset done");
    endtask

    task automatic test_random();
        int pending_q [$];
        set_idle();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pending_q.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r] > 0) pending_q.push_back(r);
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            if (pending_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_en   = 1'b1;
                wb_addr = 5'(pending_q[$urandom_range(0, pending_q.size() - 1)]);
            end else begin
                wb_en   = ($urandom_range(0, 15) == 0);
                wb_addr = 5'($urandom_range(0, 7));
            end
            #2;
            checks++;
            if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr) ||
                stall !== exp_stall() || err_underflow !== m_err) begin
                errors++;
                $display("FAIL rand%0d rs1=%h/%h rs2=%h/%h stall=%b/%b err=%b/%b (got/required)",
                         n, rs1_data, exp_read(rs1_addr), rs2_data, exp_read(rs2_addr),
                         stall, exp_stall(), err_underflow, m_err);
            end
            tick();
        end
        set_idle();
        for (int r = 0; r < NR; r++) begin
            rs1_addr = 5'(r);
            #1;
            checks++;
            if (rs1_data !== exp_read(rs1_addr)) begin
                errors++;
                $display("FAIL rand_final x%0d got=%h required=%h", r, rs1_data, exp_read(rs1_addr));
            end
        end
        $display("test_random done");
    endtask

    initial begin
        set_idle();
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_bypass();
        test_x0();
        test_raw_stall();
        test_saturate();
        test_underflow_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
